// File: rtl/mix_column.sv
// AES MixColumns / InvMixColumns over a 128-bit state, one registered stage.
// All four columns are transformed in parallel with pure XOR/xtime logic.
module mix_column (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         out_valid
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of the column product; rows 1..3 reuse it on a rotated column.
  function automatic logic [7:0] row0(input logic [7:0] a0, input logic [7:0] a1,
                                      input logic [7:0] a2, input logic [7:0] a3,
                                      input logic       iv);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] a  [4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int unsigned k = 0; k < 4; k++) begin
      x1[k] = xt(a[k]);
      x2[k] = xt(x1[k]);
      x3[k] = xt(x2[k]);
    end
    if (iv)
      row0 = (x3[0] ^ x2[0] ^ x1[0])      // 0e
           ^ (x3[1] ^ x1[1] ^ a[1])       // 0b
           ^ (x3[2] ^ x2[2] ^ a[2])       // 0d
           ^ (x3[3] ^ a[3]);              // 09
    else
      row0 = x1[0] ^ (x1[1] ^ a[1]) ^ a[2] ^ a[3];
  endfunction

  function automatic logic [31:0] col_mix(input logic [31:0] c, input logic iv);
    logic [7:0] b0, b1, b2, b3;
    b0 = c[31:24]; b1 = c[23:16]; b2 = c[15:8]; b3 = c[7:0];
    col_mix = {row0(b0, b1, b2, b3, iv),
               row0(b1, b2, b3, b0, iv),
               row0(b2, b3, b0, b1, iv),
               row0(b3, b0, b1, b2, iv)};
  endfunction

  logic [127:0] result;

  always_comb begin
    result = '0;
    for (int unsigned c = 0; c < 4; c++)
      result[32*(3-c) +: 32] = col_mix(din[32*(3-c) +: 32], inv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        dout <= result;
    end
  end

endmodule

// File: tb/tb_mix_column.sv
// Scoreboard bench for mix_column: driver queues expectations, monitor checks.
module tb_mix_column;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         inv = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] dout;
  logic         out_valid;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] expq [$];

  mix_column dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inv(inv),
    .din(din), .dout(dout), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] x, input logic iv);
    logic [7:0] coef [4];
    logic [7:0] s [16];
    logic [7:0] r [16];
    logic [127:0] o;
    if (iv) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
    else    begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
    for (int k = 0; k < 16; k++) s[k] = x[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) begin
        r[4*c+j] = '0;
        for (int k = 0; k < 4; k++)
          r[4*c+j] ^= gmul(coef[(k - j + 4) % 4], s[4*c+k]);
      end
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = r[k];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [127:0] d, input logic iv, input logic [127:0] e);
    @(negedge clk);
    in_valid = 1'b1; din = d; inv = iv;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; din = {4{$urandom}}; inv = 1'($urandom);
    end
  endtask

  // Monitor: one result per out_valid cycle, in issue order
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (expq.size() == 0) check("unexpected_out_valid", {127'd0, out_valid}, 128'd0);
        else check("dout", dout, expq.pop_front());
      end
    end
  end

  localparam logic [127:0] V_SB  = 128'h00000000_00000000_00000000_00000001;
  localparam logic [127:0] V_SBO = 128'h00000000_00000000_00000000_01010302;
  localparam logic [127:0] V_UC  = 128'h00000000_00000000_00000000_11111111;
  localparam logic [127:0] V_AI  = 128'h63f230fe_6b01d77c_67ab776f_767bc52b;
  localparam logic [127:0] V_AO  = 128'h0532e880_7e775b93_30dc93ab_8fffe172;

  initial begin
    logic [127:0] x, y;
    #2;
    check("reset_dout", dout, '0);
    check("reset_out_valid", {127'd0, out_valid}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors streamed back-to-back
    issue(V_SB, 1'b0, V_SBO);
    issue(V_UC, 1'b0, V_UC);
    issue(V_AI, 1'b0, V_AO);
    issue(V_AO, 1'b1, V_AI);
    issue(V_SBO, 1'b1, V_SB);
    issue(V_SB, 1'b0, V_SBO);
    issue(V_UC, 1'b0, V_UC);
    issue(V_AI, 1'b0, V_AO);

    // Hold: in_valid low, din wiggles, dout keeps the last result
    idle(1);
    din = 'x;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_valid", {127'd0, out_valid}, '0);
      check("hold_dout", dout, V_AO);
      din = {4{$urandom}};
    end

    // Randomized stream with gaps
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = 128'(1'($urandom));
      issue(x, y[0], model(x, y[0]));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Round trips: inverse of forward must return the original
    for (int i = 0; i < 20; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = model(x, 1'b0);
      issue(x, 1'b0, y);
      issue(y, 1'b1, x);
    end

    // Async reset between edges while dout is nonzero
    issue(V_AI, 1'b0, V_AO);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout, '0);
    check("async_rst_out_valid", {127'd0, out_valid}, '0);
    issue(V_SB, 1'b0, 128'd0);
    expq.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_held_dout", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(V_AO, 1'b1, V_AI);
    idle(3);

    if (expq.size() != 0) check("pending_results", 128'(expq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mix_column.md
# mix_column

AES MixColumns round transform with an optional InvMixColumns mode. It takes a 128-bit AES state and multiplies each 32-bit column by the fixed circulant GF(2^8) matrix. The result is registered. It sits in the AES round datapath between ShiftRows and AddRoundKey.

## Interface
Parameters: none.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  input  1  din and inv are valid this cycle.
- inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_valid.
- din  input  128  AES state.
- dout  output  128  transformed state, registered.
- out_valid  output  1  dout updated with a new result this cycle.

## Operation
- State byte layout:
  - din[127:120] is byte 0; byte k is din[127-8k -: 8].
  - Column c (0..3) is bytes 4c..4c+3, i.e. din[127-32c -: 32].
  - Byte 4c is row 0 (the most significant byte of the column word).
- Forward mode (inv=0), for column (a0,a1,a2,a3):
  - r0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - r1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - r2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - r3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- Inverse mode (inv=1): same structure with coefficients 0e, 0b, 0d, 09.
  - r0 = e·a0 ^ b·a1 ^ d·a2 ^ 9·a3; rotate the coefficient row right by one for each next row.
- GF(2^8) arithmetic:
  - Polynomial x^8+x^4+x^3+x+1.
  - xtime(b) = (b<<1)[7:0] ^ (b[7] ? 8'h1b : 0).
  - 3·b = xtime(b)^b; 9, b, d and e are built from repeated xtime and XOR.
- All four columns are computed in parallel in the combinational stage, which is purely XOR logic with no lookup tables.
- Output register:
  - If in_valid=1 at a rising edge, dout <= result(din, inv).
  - If in_valid=0, dout holds its previous value.
- Back-to-back operation: a new input is accepted every cycle. There is no backpressure and no ready signal.
- Invariant: the XOR of the four output bytes of a column equals the XOR of its four input bytes, in both modes.
- Inverse check: InvMixColumns(MixColumns(x)) = x for any x.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on dout, with out_valid=1, after edge N.
- out_valid <= in_valid on every edge, so it is high for exactly one cycle per accepted input.
- Reset:
  - Asserting rst_n=0 immediately clears dout to 128'h0 and out_valid to 0, regardless of clk.
  - Reset asserted mid-stream discards any in-flight result.
  - The first input is accepted at the first rising edge with rst_n=1.
- X/unknown inputs when in_valid=0 must not propagate to dout.

## Test plan
- Forward single bit: din=00000000_00000000_00000000_00000001, inv=0 -> dout=00000000_00000000_00000000_01010302 one cycle later, out_valid=1.
- Forward uniform column: din=00000000_00000000_00000000_11111111, inv=0 -> dout unchanged, 00000000_00000000_00000000_11111111.
- Forward AES vector: din=63f230fe_6b01d77c_67ab776f_767bc52b, inv=0 -> dout=0532e880_7e775b93_30dc93ab_8fffe172.
- Inverse AES vector: din=0532e880_7e775b93_30dc93ab_8fffe172, inv=1 -> dout=63f230fe_6b01d77c_67ab776f_767bc52b. Also din=...01010302, inv=1 -> ...00000001.
- Streaming and hold:
  - Drive the three forward vectors on consecutive cycles -> three consecutive out_valid=1 cycles with the correct douts in order.
  - Then drop in_valid -> out_valid=0 and dout holds 0532e880_... from the last input; din changes are ignored.
- Async reset: pull rst_n low between clock edges while dout is nonzero -> dout=0 and out_valid=0 immediately. Release -> the first edge with in_valid=1 produces the correct result.
